// File: rtl/instruction_decode.sv
// ---------------------------------------------------------------------------
// instruction_decode
//
// Purpose:
//   ID stage of a five-stage MIPS-style pipeline. Decodes the IF/ID word, reads
//   the 32x32 register file (write-first), resolves beq/bne in ID, detects
//   load-use and branch-operand hazards and loads the ID/EX pipeline register.
//
// Configuration:
//   ID_BNE_EN  - when defined, opcode 0x05 decodes as bne. When undefined,
//                0x05 is a nop and no bne compare or hazard logic is built.
//
// Parameters:
//   PC_INC     - byte increment added to the IF/ID pc for the branch target.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   instructionFetchReg[63:0]  IF/ID register: [63:32] instruction, [31:0] pc
//   wbRegWrite/wbAddr/wbData   register file write port
//   exMemRegWrite/exMemRd      EX/MEM destination for the branch hazard check
//   branchResult, branchAddrs  branch taken this cycle and its target (comb.)
//   regStall                   IF/ID load enable (1 = load, 0 = hold)
//   muxStall                   1 = hold PC
//   idEx*                      registered ID/EX pipeline fields
// ---------------------------------------------------------------------------
module instruction_decode #(
    parameter int unsigned PC_INC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] instructionFetchReg,
    input  logic        wbRegWrite,
    input  logic [4:0]  wbAddr,
    input  logic [31:0] wbData,
    input  logic        exMemRegWrite,
    input  logic [4:0]  exMemRd,
    output logic        branchResult,
    output logic [31:0] branchAddrs,
    output logic        regStall,
    output logic        muxStall,
    output logic [31:0] idExPc,
    output logic [31:0] idExRsData,
    output logic [31:0] idExRtData,
    output logic [31:0] idExImm,
    output logic [4:0]  idExRs,
    output logic [4:0]  idExRt,
    output logic [4:0]  idExRd,
    output logic        idExRegWrite,
    output logic        idExMemRead,
    output logic        idExMemWrite,
    output logic        idExMemToReg,
    output logic        idExAluSrc,
    output logic        idExRegDst,
    output logic [2:0]  idExAluOp
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef ID_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic [2:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        ctrl_t       ctrl;
    } idex_t;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [31:0] instr_s;
    logic [31:0] pc_s;
    logic [5:0]  opcode_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [5:0]  funct_s;
    logic [31:0] imm_s;

    assign instr_s  = instructionFetchReg[63:32];
    assign pc_s     = instructionFetchReg[31:0];
    assign opcode_s = instr_s[31:26];
    assign rs_s     = instr_s[25:21];
    assign rt_s     = instr_s[20:16];
    assign rd_s     = instr_s[15:11];
    assign funct_s  = instr_s[5:0];
    assign imm_s    = {{16{instr_s[15]}}, instr_s[15:0]};

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] rf_q [32];
    logic [31:0] rs_data_s;
    logic [31:0] rt_data_s;

    // Register file write port; $0 is never written so it always reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (wbRegWrite && (wbAddr != 5'd0)) begin
            rf_q[wbAddr] <= wbData;
        end
    end

    // Write-first reads: a writeback landing this cycle is visible to the
    // instruction being decoded, so no WB->ID forwarding is needed elsewhere.
    assign rs_data_s = (rs_s == 5'd0) ? 32'd0 :
                       (wbRegWrite && (wbAddr == rs_s)) ? wbData : rf_q[rs_s];
    assign rt_data_s = (rt_s == 5'd0) ? 32'd0 :
                       (wbRegWrite && (wbAddr == rt_s)) ? wbData : rf_q[rt_s];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    ctrl_t ctrl_s;
    logic  is_beq_s;
    logic  uses_rt_s;
`ifdef ID_BNE_EN
    logic  is_bne_s;
`endif

    // Opcode/funct decode into ID/EX control bits; anything unknown is a nop.
    always_comb begin
        ctrl_s    = '0;
        is_beq_s  = 1'b0;
        uses_rt_s = 1'b0;
`ifdef ID_BNE_EN
        is_bne_s  = 1'b0;
`endif
        case (opcode_s)
            OP_RTYPE: begin
                // rt is a source for every R-type word, even an unknown funct,
                // so the load-use check stays conservative.
                uses_rt_s = 1'b1;
                case (funct_s)
                    FN_ADD: begin
                        ctrl_s.reg_write = (rd_s != 5'd0);
                        ctrl_s.reg_dst   = 1'b1;
                        ctrl_s.alu_op    = ALU_ADD;
                    end
                    FN_SUB: begin
                        ctrl_s.reg_write = (rd_s != 5'd0);
                        ctrl_s.reg_dst   = 1'b1;
                        ctrl_s.alu_op    = ALU_SUB;
                    end
                    FN_AND: begin
                        ctrl_s.reg_write = (rd_s != 5'd0);
                        ctrl_s.reg_dst   = 1'b1;
                        ctrl_s.alu_op    = ALU_AND;
                    end
                    FN_OR: begin
                        ctrl_s.reg_write = (rd_s != 5'd0);
                        ctrl_s.reg_dst   = 1'b1;
                        ctrl_s.alu_op    = ALU_OR;
                    end
                    FN_SLT: begin
                        ctrl_s.reg_write = (rd_s != 5'd0);
                        ctrl_s.reg_dst   = 1'b1;
                        ctrl_s.alu_op    = ALU_SLT;
                    end
                    default: begin
                        ctrl_s = '0;
                    end
                endcase
            end
            OP_LW: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_read   = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.alu_src    = 1'b1;
                ctrl_s.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                uses_rt_s         = 1'b1;
                ctrl_s.mem_write  = 1'b1;
                ctrl_s.alu_src    = 1'b1;
                ctrl_s.alu_op     = ALU_ADD;
            end
            OP_ADDI: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.alu_src    = 1'b1;
                ctrl_s.alu_op     = ALU_ADD;
            end
            OP_BEQ: begin
                // Resolved here; the ID/EX copy only carries a compare op.
                is_beq_s          = 1'b1;
                uses_rt_s         = 1'b1;
                ctrl_s.alu_op     = ALU_SUB;
            end
`ifdef ID_BNE_EN
            OP_BNE: begin
                is_bne_s          = 1'b1;
                uses_rt_s         = 1'b1;
                ctrl_s.alu_op     = ALU_SUB;
            end
`endif
            default: begin
                ctrl_s = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hazards and branch resolution
    // ------------------------------------------------------------------
    idex_t       idex_q;
    idex_t       idex_d;
    logic [4:0]  ex_dest_s;
    logic        is_branch_s;
    logic        load_use_s;
    logic        branch_haz_s;
    logic        stall_s;
    logic        operands_eq_s;
    logic        taken_s;
    logic [31:0] target_s;

    // True when a nonzero branch source is still being produced in EX or MEM.
    function automatic logic src_pending(input logic [4:0] src,
                                         input logic [4:0] ex_dest,
                                         input logic       ex_wr,
                                         input logic [4:0] mem_dest,
                                         input logic       mem_wr);
        return (src != 5'd0) &&
               ((ex_wr && (src == ex_dest)) || (mem_wr && (src == mem_dest)));
    endfunction

    assign ex_dest_s = idex_q.ctrl.reg_dst ? idex_q.rd : idex_q.rt;

`ifdef ID_BNE_EN
    assign is_branch_s = is_beq_s | is_bne_s;
`else
    assign is_branch_s = is_beq_s;
`endif

    assign load_use_s = idex_q.ctrl.mem_read && (idex_q.rt != 5'd0) &&
                        ((idex_q.rt == rs_s) || (uses_rt_s && (idex_q.rt == rt_s)));

    assign branch_haz_s = is_branch_s &&
        (src_pending(rs_s, ex_dest_s, idex_q.ctrl.reg_write, exMemRd, exMemRegWrite) ||
         src_pending(rt_s, ex_dest_s, idex_q.ctrl.reg_write, exMemRd, exMemRegWrite));

    assign stall_s       = load_use_s | branch_haz_s;
    assign operands_eq_s = (rs_data_s == rt_data_s);

    // A stalled branch never resolves; it retries with the held IF/ID word.
`ifdef ID_BNE_EN
    assign taken_s = !stall_s && ((is_beq_s && operands_eq_s) || (is_bne_s && !operands_eq_s));
`else
    assign taken_s = !stall_s && is_beq_s && operands_eq_s;
`endif

    assign target_s = pc_s + 32'(PC_INC) + {imm_s[29:0], 2'b00};

    // Front-end control; reset forces a quiet "load IF/ID, no branch" state.
    always_comb begin
        if (reset) begin
            branchResult = 1'b0;
            branchAddrs  = 32'd0;
            muxStall     = 1'b0;
            regStall     = 1'b1;
        end else begin
            branchResult = taken_s;
            branchAddrs  = target_s;
            muxStall     = stall_s;
            regStall     = !stall_s;
        end
    end

    // ------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------

    // Next ID/EX contents: a full zero bubble while stalled, else the decode.
    always_comb begin
        idex_d = '0;
        if (stall_s) begin
            idex_d = '0;
        end else begin
            idex_d.pc      = pc_s;
            idex_d.rs_data = rs_data_s;
            idex_d.rt_data = rt_data_s;
            idex_d.imm     = imm_s;
            idex_d.rs      = rs_s;
            idex_d.rt      = rt_s;
            idex_d.rd      = rd_s;
            idex_d.ctrl    = ctrl_s;
        end
    end

    // ID/EX register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign idExPc       = idex_q.pc;
    assign idExRsData   = idex_q.rs_data;
    assign idExRtData   = idex_q.rt_data;
    assign idExImm      = idex_q.imm;
    assign idExRs       = idex_q.rs;
    assign idExRt       = idex_q.rt;
    assign idExRd       = idex_q.rd;
    assign idExRegWrite = idex_q.ctrl.reg_write;
    assign idExMemRead  = idex_q.ctrl.mem_read;
    assign idExMemWrite = idex_q.ctrl.mem_write;
    assign idExMemToReg = idex_q.ctrl.mem_to_reg;
    assign idExAluSrc   = idex_q.ctrl.alu_src;
    assign idExRegDst   = idex_q.ctrl.reg_dst;
    assign idExAluOp    = idex_q.ctrl.alu_op;

endmodule

// File: tb/tb_instruction_decode.sv
// ---------------------------------------------------------------------------
// tb_instruction_decode
//
// Directed bench for instruction_decode: a table of single-instruction decode
// vectors with hand-computed outputs, followed by hand-written sequences for
// reset, write-first reads, load-use and branch hazards, and reset mid-stall.
// Honours ID_BNE_EN for the bne vector.
// ---------------------------------------------------------------------------
module tb_instruction_decode;

    logic        clk;
    logic        reset;
    logic [63:0] instructionFetchReg;
    logic        wbRegWrite;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        exMemRegWrite;
    logic [4:0]  exMemRd;
    logic        branchResult;
    logic [31:0] branchAddrs;
    logic        regStall;
    logic        muxStall;
    logic [31:0] idExPc;
    logic [31:0] idExRsData;
    logic [31:0] idExRtData;
    logic [31:0] idExImm;
    logic [4:0]  idExRs;
    logic [4:0]  idExRt;
    logic [4:0]  idExRd;
    logic        idExRegWrite;
    logic        idExMemRead;
    logic        idExMemWrite;
    logic        idExMemToReg;
    logic        idExAluSrc;
    logic        idExRegDst;
    logic [2:0]  idExAluOp;

    int checks   = 0;
    int failures = 0;

    instruction_decode #(.PC_INC(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .instructionFetchReg (instructionFetchReg),
        .wbRegWrite          (wbRegWrite),
        .wbAddr              (wbAddr),
        .wbData              (wbData),
        .exMemRegWrite       (exMemRegWrite),
        .exMemRd             (exMemRd),
        .branchResult        (branchResult),
        .branchAddrs         (branchAddrs),
        .regStall            (regStall),
        .muxStall            (muxStall),
        .idExPc              (idExPc),
        .idExRsData          (idExRsData),
        .idExRtData          (idExRtData),
        .idExImm             (idExImm),
        .idExRs              (idExRs),
        .idExRt              (idExRt),
        .idExRd              (idExRd),
        .idExRegWrite        (idExRegWrite),
        .idExMemRead         (idExMemRead),
        .idExMemWrite        (idExMemWrite),
        .idExMemToReg        (idExMemToReg),
        .idExAluSrc          (idExAluSrc),
        .idExRegDst          (idExRegDst),
        .idExAluOp           (idExAluOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exp_br;
        logic [31:0] exp_baddr;
        logic [8:0]  exp_ctrl;   // {rw, mr, mw, m2r, asrc, rdst, aluop[2:0]}
        logic [31:0] exp_rsd;
        logic [31:0] exp_rtd;
        logic [31:0] exp_imm;
    } vec_t;

    vec_t vecs[20];
    int   nvec = 0;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic add_vec(input string name, input logic [31:0] instr, input logic [31:0] pc,
                           input logic br, input logic [31:0] baddr, input logic [8:0] ctrl,
                           input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm);
        vecs[nvec].name      = name;
        vecs[nvec].instr     = instr;
        vecs[nvec].pc        = pc;
        vecs[nvec].exp_br    = br;
        vecs[nvec].exp_baddr = baddr;
        vecs[nvec].exp_ctrl  = ctrl;
        vecs[nvec].exp_rsd   = rsd;
        vecs[nvec].exp_rtd   = rtd;
        vecs[nvec].exp_imm   = imm;
        nvec++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        instructionFetchReg = 64'd0;
        wbRegWrite = 1'b1;
        wbAddr     = a;
        wbData     = d;
        tick();
        wbRegWrite = 1'b0;
    endtask

    function automatic logic [31:0] ctrl_vec();
        return {23'd0, idExRegWrite, idExMemRead, idExMemWrite, idExMemToReg,
                idExAluSrc, idExRegDst, idExAluOp};
    endfunction

    function automatic logic [31:0] regs_vec();
        return {17'd0, idExRs, idExRt, idExRd};
    endfunction

    initial begin
        reset = 1'b1;
        instructionFetchReg = {enc_i(6'h04, 5'd0, 5'd0, 16'h0003), 32'h0000_0010};
        wbRegWrite = 1'b0;
        wbAddr = 5'd0;
        wbData = 32'd0;
        exMemRegWrite = 1'b0;
        exMemRd = 5'd0;

        // ---------------- Reset ----------------
        tick();
        tick();
        check("rst_branchResult", {31'd0, branchResult}, 32'd0);
        check("rst_branchAddrs",  branchAddrs, 32'd0);
        check("rst_muxStall",     {31'd0, muxStall}, 32'd0);
        check("rst_regStall",     {31'd0, regStall}, 32'd1);
        check("rst_idex_ctrl",    ctrl_vec(), 32'd0);
        check("rst_idex_pc",      idExPc, 32'd0);

        reset = 1'b0;
        instructionFetchReg = 64'd0;
        settle();
        check("nop_branchResult", {31'd0, branchResult}, 32'd0);
        check("nop_muxStall",     {31'd0, muxStall}, 32'd0);
        check("nop_regStall",     {31'd0, regStall}, 32'd1);
        tick();
        check("nop_idex_ctrl",    ctrl_vec(), 32'd0);
        check("nop_idex_pc",      idExPc, 32'd0);
        check("nop_idex_rsd",     idExRsData, 32'd0);
        check("nop_idex_rtd",     idExRtData, 32'd0);
        check("nop_idex_imm",     idExImm, 32'd0);
        check("nop_idex_regs",    regs_vec(), 32'd0);

        // ---------------- Register preload ----------------
        wb_write(5'd1, 32'h0000_0011);
        wb_write(5'd2, 32'h0000_0022);
        wb_write(5'd4, 32'h0000_0044);
        wb_write(5'd8, 32'h0000_0005);
        wb_write(5'd9, 32'h0000_0005);
        wb_write(5'd0, 32'h0000_DEAD);

        // ---------------- Decode table ----------------
        add_vec("add",     enc_r(5'd1, 5'd2, 5'd3, 6'h20),  32'h0000_0100, 1'b0, 32'h0000_6184,
                9'b100001000, 32'h11, 32'h22, 32'h0000_1820);
        add_vec("sub",     enc_r(5'd4, 5'd1, 5'd5, 6'h22),  32'h0000_0000, 1'b0, 32'h0000_A08C,
                9'b100001001, 32'h44, 32'h11, 32'h0000_2822);
        add_vec("and",     enc_r(5'd1, 5'd2, 5'd6, 6'h24),  32'h0000_0000, 1'b0, 32'h0000_C094,
                9'b100001010, 32'h11, 32'h22, 32'h0000_3024);
        add_vec("or",      enc_r(5'd2, 5'd4, 5'd7, 6'h25),  32'h0000_0000, 1'b0, 32'h0000_E098,
                9'b100001011, 32'h22, 32'h44, 32'h0000_3825);
        add_vec("slt",     enc_r(5'd1, 5'd4, 5'd10, 6'h2A), 32'h0000_0000, 1'b0, 32'h0001_40AC,
                9'b100001100, 32'h11, 32'h44, 32'h0000_502A);
        add_vec("add_rd0", enc_r(5'd1, 5'd2, 5'd0, 6'h20),  32'h0000_0000, 1'b0, 32'h0000_0084,
                9'b000001000, 32'h11, 32'h22, 32'h0000_0020);
        add_vec("badfn",   enc_r(5'd1, 5'd2, 5'd3, 6'h21),  32'h0000_0000, 1'b0, 32'h0000_6088,
                9'b000000000, 32'h11, 32'h22, 32'h0000_1821);
        add_vec("lw",      enc_i(6'h23, 5'd1, 5'd2, 16'h0008), 32'h0000_0040, 1'b0, 32'h0000_0064,
                9'b110110000, 32'h11, 32'h22, 32'h0000_0008);
        add_vec("sw",      enc_i(6'h2B, 5'd1, 5'd4, 16'hFFFC), 32'h0000_0040, 1'b0, 32'h0000_0034,
                9'b001010000, 32'h11, 32'h44, 32'hFFFF_FFFC);
        add_vec("addi",    enc_i(6'h08, 5'd2, 5'd5, 16'hFFFF), 32'h0000_0000, 1'b0, 32'h0000_0000,
                9'b100010000, 32'h22, 32'h00, 32'hFFFF_FFFF);
        add_vec("beq_tk",  enc_i(6'h04, 5'd8, 5'd9, 16'h0003), 32'h0000_0010, 1'b1, 32'h0000_0020,
                9'b000000001, 32'h05, 32'h05, 32'h0000_0003);
        add_vec("beq_nt",  enc_i(6'h04, 5'd1, 5'd2, 16'h0003), 32'h0000_0010, 1'b0, 32'h0000_0020,
                9'b000000001, 32'h11, 32'h22, 32'h0000_0003);
        add_vec("badop",   enc_i(6'h3F, 5'd1, 5'd2, 16'h0010), 32'h0000_0000, 1'b0, 32'h0000_0044,
                9'b000000000, 32'h11, 32'h22, 32'h0000_0010);
`ifdef ID_BNE_EN
        add_vec("bne",     enc_i(6'h05, 5'd1, 5'd2, 16'hFFFE), 32'h0000_0080, 1'b1, 32'h0000_007C,
                9'b000000001, 32'h11, 32'h22, 32'hFFFF_FFFE);
`else
        add_vec("bne_off", enc_i(6'h05, 5'd1, 5'd2, 16'hFFFE), 32'h0000_0080, 1'b0, 32'h0000_007C,
                9'b000000000, 32'h11, 32'h22, 32'hFFFF_FFFE);
`endif
        add_vec("beq_wrap", enc_i(6'h04, 5'd8, 5'd9, 16'h0003), 32'hFFFF_FFF0, 1'b1, 32'h0000_0000,
                9'b000000001, 32'h05, 32'h05, 32'h0000_0003);
        add_vec("add_r0",  enc_r(5'd0, 5'd1, 5'd3, 6'h20),  32'h0000_0000, 1'b0, 32'h0000_6084,
                9'b100001000, 32'h00, 32'h11, 32'h0000_1820);

        for (int i = 0; i < nvec; i++) begin
            instructionFetchReg = {vecs[i].instr, vecs[i].pc};
            settle();
            check({vecs[i].name, "_muxStall"},     {31'd0, muxStall}, 32'd0);
            check({vecs[i].name, "_regStall"},     {31'd0, regStall}, 32'd1);
            check({vecs[i].name, "_branchResult"}, {31'd0, branchResult}, {31'd0, vecs[i].exp_br});
            check({vecs[i].name, "_branchAddrs"},  branchAddrs, vecs[i].exp_baddr);
            tick();
            check({vecs[i].name, "_ctrl"},  ctrl_vec(), {23'd0, vecs[i].exp_ctrl});
            check({vecs[i].name, "_rsd"},   idExRsData, vecs[i].exp_rsd);
            check({vecs[i].name, "_rtd"},   idExRtData, vecs[i].exp_rtd);
            check({vecs[i].name, "_imm"},   idExImm, vecs[i].exp_imm);
            check({vecs[i].name, "_pc"},    idExPc, vecs[i].pc);
            check({vecs[i].name, "_regs"},  regs_vec(),
                  {17'd0, vecs[i].instr[25:21], vecs[i].instr[20:16], vecs[i].instr[15:11]});
            instructionFetchReg = 64'd0;
            tick();
        end

        // ---------------- Write-first read ----------------
        instructionFetchReg = {enc_r(5'd6, 5'd0, 5'd7, 6'h25), 32'h0000_0050};
        wbRegWrite = 1'b1;
        wbAddr = 5'd6;
        wbData = 32'h0000_ABCD;
        tick();
        wbRegWrite = 1'b0;
        check("wf_rsd", idExRsData, 32'h0000_ABCD);
        check("wf_rd",  {27'd0, idExRd}, 32'd7);
        tick();
        check("wf_persist_rsd", idExRsData, 32'h0000_ABCD);
        instructionFetchReg = 64'd0;
        tick();

        // ---------------- Load-use hazard ----------------
        instructionFetchReg = {enc_i(6'h23, 5'd1, 5'd2, 16'h0000), 32'h0000_0020};
        tick();
        instructionFetchReg = {enc_r(5'd2, 5'd4, 5'd3, 6'h20), 32'h0000_0024};
        settle();
        check("lu_muxStall",     {31'd0, muxStall}, 32'd1);
        check("lu_regStall",     {31'd0, regStall}, 32'd0);
        check("lu_branchResult", {31'd0, branchResult}, 32'd0);
        tick();
        check("lu_bubble_ctrl",  ctrl_vec(), 32'd0);
        check("lu_bubble_pc",    idExPc, 32'd0);
        check("lu_bubble_rsd",   idExRsData, 32'd0);
        check("lu_release_mux",  {31'd0, muxStall}, 32'd0);
        check("lu_release_reg",  {31'd0, regStall}, 32'd1);
        tick();
        check("lu_add_regwrite", {31'd0, idExRegWrite}, 32'd1);
        check("lu_add_rd",       {27'd0, idExRd}, 32'd3);
        check("lu_add_rsd",      idExRsData, 32'h0000_0022);
        instructionFetchReg = 64'd0;
        tick();

        // Load into $0 is never a hazard
        instructionFetchReg = {enc_i(6'h23, 5'd1, 5'd0, 16'h0000), 32'h0000_0020};
        tick();
        instructionFetchReg = {enc_r(5'd0, 5'd4, 5'd3, 6'h20), 32'h0000_0024};
        settle();
        check("lu_r0_muxStall", {31'd0, muxStall}, 32'd0);
        tick();
        instructionFetchReg = 64'd0;
        tick();

        // ---------------- Branch hazard: EX then MEM then resolve ----------------
        instructionFetchReg = {enc_i(6'h08, 5'd0, 5'd5, 16'h0007), 32'h0000_002C};
        tick();
        instructionFetchReg = {enc_i(6'h04, 5'd5, 5'd0, 16'h0002), 32'h0000_0030};
        settle();
        check("bh_ex_muxStall",     {31'd0, muxStall}, 32'd1);
        check("bh_ex_branchResult", {31'd0, branchResult}, 32'd0);
        tick();
        exMemRegWrite = 1'b1;
        exMemRd = 5'd5;
        settle();
        check("bh_mem_muxStall", {31'd0, muxStall}, 32'd1);
        check("bh_mem_regStall", {31'd0, regStall}, 32'd0);
        tick();
        exMemRegWrite = 1'b0;
        exMemRd = 5'd0;
        wbRegWrite = 1'b1;
        wbAddr = 5'd5;
        wbData = 32'h0000_0007;
        settle();
        check("bh_wb_muxStall",     {31'd0, muxStall}, 32'd0);
        check("bh_wb_regStall",     {31'd0, regStall}, 32'd1);
        check("bh_wb_branchResult", {31'd0, branchResult}, 32'd0);
        check("bh_wb_branchAddrs",  branchAddrs, 32'h0000_003C);
        tick();
        wbRegWrite = 1'b0;
        check("bh_entry_ctrl", ctrl_vec(), 32'd1);
        instructionFetchReg = 64'd0;
        tick();

        // ---------------- Stall beats a taken branch ----------------
        exMemRegWrite = 1'b1;
        exMemRd = 5'd9;
        instructionFetchReg = {enc_i(6'h04, 5'd8, 5'd9, 16'h0003), 32'h0000_0010};
        settle();
        check("prio_stall_br",  {31'd0, branchResult}, 32'd0);
        check("prio_stall_mux", {31'd0, muxStall}, 32'd1);
        tick();
        exMemRegWrite = 1'b0;
        settle();
        check("prio_go_br",    {31'd0, branchResult}, 32'd1);
        check("prio_go_mux",   {31'd0, muxStall}, 32'd0);
        check("prio_go_addr",  branchAddrs, 32'h0000_0020);
        tick();
        instructionFetchReg = 64'd0;
        tick();

        // ---------------- Reset mid-stall ----------------
        instructionFetchReg = {enc_i(6'h23, 5'd1, 5'd2, 16'h0000), 32'h0000_0020};
        tick();
        instructionFetchReg = {enc_r(5'd2, 5'd4, 5'd3, 6'h20), 32'h0000_0024};
        settle();
        check("rs_pre_muxStall", {31'd0, muxStall}, 32'd1);
        reset = 1'b1;
        settle();
        check("rs_in_muxStall", {31'd0, muxStall}, 32'd0);
        check("rs_in_regStall", {31'd0, regStall}, 32'd1);
        tick();
        reset = 1'b0;
        instructionFetchReg = {enc_r(5'd1, 5'd2, 5'd3, 6'h20), 32'h0000_0000};
        settle();
        check("rs_post_memread", {31'd0, idExMemRead}, 32'd0);
        check("rs_post_muxStall", {31'd0, muxStall}, 32'd0);
        tick();
        check("rs_post_rsd", idExRsData, 32'd0);
        check("rs_post_rtd", idExRtData, 32'd0);
        instructionFetchReg = 64'd0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
